// File: rtl/rota_derecha_secuencial.sv
// Bit-serial decoder: undoes a rotate-left (by rotating right) or a logical
// shift-right (by shifting left, zero fill), one bit-step per clock.
module rota_derecha_secuencial #(
    parameter int ANCHO      = 8,
    parameter int ANCHO_CANT = $clog2(ANCHO)
) (
    input  logic                  Reloj,
    input  logic                  Reinicio_n,
    input  logic [ANCHO-1:0]      Entrada,
    input  logic [ANCHO_CANT-1:0] Cantidad,
    input  logic                  Modo,
    input  logic                  Inicio,
    output logic                  Listo,
    output logic                  Ocupado,
    output logic [ANCHO-1:0]      Salida,
    output logic                  Valido,
    input  logic                  Acepta,
    output logic [7:0]            Operaciones
);

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        DESPLAZA = 2'd1,
        ENTREGA  = 2'd2
    } estado_t;

    localparam logic [ANCHO_CANT-1:0] UNO = ANCHO_CANT'(1);

    estado_t               estado_q;
    logic [ANCHO-1:0]      trabajo_q;
    logic [ANCHO_CANT-1:0] cuenta_q;
    logic                  modo_q;
    logic [7:0]            ops_q;

    always_ff @(posedge Reloj or negedge Reinicio_n) begin
        if (!Reinicio_n) begin
            estado_q  <= ESPERA;
            trabajo_q <= '0;
            cuenta_q  <= '0;
            modo_q    <= 1'b0;
            ops_q     <= 8'd0;
        end else begin
            case (estado_q)
                ESPERA: begin
                    if (Inicio) begin
                        trabajo_q <= Entrada;
                        cuenta_q  <= Cantidad;
                        modo_q    <= Modo;
                        estado_q  <= (Cantidad == '0) ? ENTREGA : DESPLAZA;
                    end
                end
                DESPLAZA: begin
                    if (modo_q)
                        trabajo_q <= {trabajo_q[ANCHO-2:0], 1'b0};
                    else
                        trabajo_q <= {trabajo_q[0], trabajo_q[ANCHO-1:1]};
                    cuenta_q <= cuenta_q - UNO;
                    if (cuenta_q == UNO)
                        estado_q <= ENTREGA;
                end
                ENTREGA: begin
                    if (Acepta) begin
                        ops_q    <= ops_q + 8'd1;
                        estado_q <= ESPERA;
                    end
                end
                default: estado_q <= ESPERA;
            endcase
        end
    end

    // The working register only changes when leaving ESPERA, so in ESPERA it
    // still holds the last delivered result and can drive Salida directly.
    assign Salida      = trabajo_q;
    assign Listo       = (estado_q == ESPERA);
    assign Ocupado     = (estado_q == DESPLAZA);
    assign Valido      = (estado_q == ENTREGA);
    assign Operaciones = ops_q;

endmodule

// File: tb/tb_rota_derecha_secuencial.sv
// Randomized self-checking bench for rota_derecha_secuencial against an
// arithmetic reference of rotate-right / shift-left by N.
module tb_rota_derecha_secuencial;

    localparam int ANCHO      = 8;
    localparam int ANCHO_CANT = 3;

    logic                  Reloj;
    logic                  Reinicio_n;
    logic [ANCHO-1:0]      Entrada;
    logic [ANCHO_CANT-1:0] Cantidad;
    logic                  Modo;
    logic                  Inicio;
    logic                  Listo;
    logic                  Ocupado;
    logic [ANCHO-1:0]      Salida;
    logic                  Valido;
    logic                  Acepta;
    logic [7:0]            Operaciones;

    int errores = 0;
    int checks  = 0;
    int ops_mod = 0;

    rota_derecha_secuencial #(.ANCHO(ANCHO), .ANCHO_CANT(ANCHO_CANT)) dut (
        .Reloj      (Reloj),
        .Reinicio_n (Reinicio_n),
        .Entrada    (Entrada),
        .Cantidad   (Cantidad),
        .Modo       (Modo),
        .Inicio     (Inicio),
        .Listo      (Listo),
        .Ocupado    (Ocupado),
        .Salida     (Salida),
        .Valido     (Valido),
        .Acepta     (Acepta),
        .Operaciones(Operaciones)
    );

    initial begin
        Reloj = 1'b0;
        forever #5 Reloj = ~Reloj;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    task automatic comprobar(input string tag, input int obs, input int esp);
        checks++;
        if (obs != esp) begin
            errores++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, esp, $time);
        end
    endtask

    // Reference: the original encoder rotated left / shifted right by n.
    function automatic int modelo(input int x, input int n, input int m);
        int r;
        if (m == 0)
            r = (n == 0) ? x : ((x >> n) | (x << (ANCHO - n)));
        else
            r = x << n;
        return r % (1 << ANCHO);
    endfunction

    // Starts and ends right after a falling edge.
    task automatic operar(input int e, input int c, input int m, input int espera,
                          input bit pulsos);
        int esp;
        comprobar("listo_previo", int'(Listo), 1);
        Entrada = e[ANCHO-1:0]; Cantidad = c[ANCHO_CANT-1:0]; Modo = m[0]; Inicio = 1'b1;
        @(negedge Reloj);
        Inicio = 1'b0;
        Entrada = ANCHO'($urandom); Cantidad = ANCHO_CANT'($urandom); Modo = 1'($urandom);
        esp = modelo(e, c, m);
        for (int i = 0; i < c; i++) begin
            comprobar("ocupado", int'(Ocupado), 1);
            comprobar("valido_temprano", int'(Valido), 0);
            Acepta = 1'($urandom);
            @(negedge Reloj);
        end
        Acepta = 1'b0;
        comprobar("valido", int'(Valido), 1);
        comprobar("ocupado_fin", int'(Ocupado), 0);
        comprobar("salida", int'(Salida), esp);
        for (int i = 0; i < espera; i++) begin
            Inicio = pulsos ? 1'($urandom) : 1'b0;
            Entrada = ANCHO'($urandom);
            Cantidad = ANCHO_CANT'($urandom);
            @(negedge Reloj);
            comprobar("bp_valido", int'(Valido), 1);
            comprobar("bp_salida", int'(Salida), esp);
            comprobar("bp_listo", int'(Listo), 0);
            comprobar("bp_ops", int'(Operaciones), ops_mod);
        end
        Acepta = 1'b1; Inicio = 1'b1;
        @(negedge Reloj);
        Acepta = 1'b0; Inicio = 1'b0;
        ops_mod = (ops_mod + 1) % 256;
        comprobar("listo_post", int'(Listo), 1);
        comprobar("ocupado_post", int'(Ocupado), 0);
        comprobar("valido_post", int'(Valido), 0);
        comprobar("ops", int'(Operaciones), ops_mod);
        comprobar("salida_retenida", int'(Salida), esp);
    endtask

    initial begin
        Reinicio_n = 1'b1; Entrada = '0; Cantidad = '0; Modo = 1'b0;
        Inicio = 1'b0; Acepta = 1'b0;
        #2 Reinicio_n = 1'b0;
        #1;
        comprobar("rst_listo", int'(Listo), 1);
        comprobar("rst_ocupado", int'(Ocupado), 0);
        comprobar("rst_valido", int'(Valido), 0);
        comprobar("rst_salida", int'(Salida), 0);
        comprobar("rst_ops", int'(Operaciones), 0);
        @(negedge Reloj);
        Reinicio_n = 1'b1;
        @(negedge Reloj);

        operar(8'h81, 2, 0, 0, 1'b0);
        operar(8'hD2, 2, 0, 1, 1'b0);
        operar(8'h2D, 2, 1, 0, 1'b0);
        operar(8'h0F, 3, 1, 2, 1'b0);
        operar(8'hA5, 0, 0, 0, 1'b0);
        operar(8'h01, 7, 0, 0, 1'b0);
        operar(8'h3C, 4, 0, 5, 1'b1);

        for (int i = 0; i < 20; i++)
            operar(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1);

        // Reset in the middle of a 7-step operation.
        Entrada = 8'hC3; Cantidad = 3'd7; Modo = 1'b0; Inicio = 1'b1;
        @(negedge Reloj);
        Inicio = 1'b0;
        repeat (3) @(negedge Reloj);
        comprobar("pre_rst_ocupado", int'(Ocupado), 1);
        Reinicio_n = 1'b0;
        #1;
        comprobar("mid_rst_valido", int'(Valido), 0);
        comprobar("mid_rst_ocupado", int'(Ocupado), 0);
        comprobar("mid_rst_listo", int'(Listo), 1);
        comprobar("mid_rst_salida", int'(Salida), 0);
        comprobar("mid_rst_ops", int'(Operaciones), 0);
        ops_mod = 0;
        @(negedge Reloj);
        Reinicio_n = 1'b1;
        @(negedge Reloj);
        comprobar("post_rst_valido", int'(Valido), 0);
        operar(8'h81, 2, 0, 0, 1'b0);

        // Counter wrap: 256 back-to-back operations.
        for (int i = 0; i < 256; i++)
            operar(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 1)), 0, 1'b0);
        comprobar("wrap_ops", int'(Operaciones), 1);

        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end

endmodule

// File: doc/rota_derecha_secuencial.md
# rota_derecha_secuencial

Iterative bit-serial inverse of the team's 2-bit rotate/shift units. One request carries a word, a step count and a mode. The block then applies one bit-step per clock, either rotate-right (undoes rotate-left) or logical shift-left (undoes shift-right, zero fill). The result is returned through a valid/accept handshake. It sits after the rotate/shift datapath in lab benches so that round-trip (encode → decode) checks run in hardware.

## Interface
- ANCHO, 8: data word width; must be a power of two, ≥ 2.
- ANCHO_CANT, $clog2(ANCHO) (3 at default): width of the step count.
- Reloj  in  1  system clock; all state updates on the rising edge.
- Reinicio_n  in  1  asynchronous, active-low reset.
- Entrada  in  ANCHO  word to decode; sampled on acceptance.
- Cantidad  in  ANCHO_CANT  number of bit-steps, 0..ANCHO-1; sampled on acceptance.
- Modo  in  1  0 = rotate right, 1 = logical shift left with zero fill; sampled on acceptance.
- Inicio  in  1  request valid.
- Listo  out  1  block can accept a request (state ESPERA).
- Ocupado  out  1  state DESPLAZA.
- Salida  out  ANCHO  result register.
- Valido  out  1  Salida holds a new result (state ENTREGA).
- Acepta  in  1  consumer takes the result.
- Operaciones  out  8  count of completed, accepted results; wraps modulo 256.

## Operation
- States: ESPERA, DESPLAZA, ENTREGA; one-hot or binary, implementer's choice.
- Output decode: Listo=1 only in ESPERA; Ocupado=1 only in DESPLAZA; Valido=1 only in ENTREGA.
- ESPERA, on Inicio=1:
  - Load the working register from Entrada, the counter from Cantidad, and latch Modo.
  - Cantidad=0 → go to ENTREGA; otherwise go to DESPLAZA.
- DESPLAZA, once per cycle:
  - Modo=0: working register ← {reg[0], reg[ANCHO-1:1]}.
  - Modo=1: working register ← {reg[ANCHO-2:0], 1'b0}.
  - Decrement the counter. The step that takes the counter from 1 to 0 moves the state to ENTREGA.
- Salida:
  - Presents the working register while in DESPLAZA and ENTREGA.
  - In ESPERA it holds the last delivered result.
- ENTREGA:
  - Salida and Valido stay stable until Acepta=1.
  - On Acepta=1: go to ESPERA and increment Operaciones (255 → 0).
- Inicio outside ESPERA is ignored; requests are not queued.
- Acepta outside ENTREGA is ignored.
- Input changes after acceptance do not affect the operation in flight.

## Timing
- Reset (Reinicio_n low) acts immediately, without waiting for Reloj:
  - State = ESPERA, Listo=1, Ocupado=0, Valido=0, Salida=0, Operaciones=0, counter=0.
  - Reset mid-operation discards the operation in flight; no partial result is delivered.
- Acceptance edge k (Inicio=1 with Listo=1): Valido rises after edge k+Cantidad.
  - Cantidad=0: Valido is high in the cycle after edge k.
  - Cantidad=N: Ocupado is high for exactly N cycles.
- Acceptance of a result in cycle j: Listo=1 from edge j+1. A same-cycle Inicio is ignored, because Listo=0 in ENTREGA.
- Minimum request-to-request spacing: Cantidad+2 cycles, given Acepta=1 on the first Valido cycle.
- Once Valido=1, Salida holds for any backpressure length.

## Test plan
- Rotate right: Entrada=8'h81, Cantidad=2, Modo=0 accepted at edge k → Ocupado high 2 cycles, Valido from edge k+2, Salida=8'h60.
- Round trip: Entrada=8'hD2 (8'hB4 rotated left by 2), Cantidad=2, Modo=0 → Salida=8'hB4. Entrada=8'h2D (8'hB4 shifted right by 2), Cantidad=2, Modo=1 → Salida=8'hB4 (bits lost by the original right shift return as 0).
- Edge counts:
  - Entrada=8'h0F, Cantidad=3, Modo=1 → Salida=8'h78.
  - Entrada=8'hA5, Cantidad=0 → Valido next cycle, Ocupado never high, Salida=8'hA5.
  - Entrada=8'h01, Cantidad=7, Modo=0 → Salida=8'h02.
- Backpressure: hold Acepta=0 for 5 cycles in ENTREGA while pulsing Inicio with new data → Salida and Valido unchanged, Listo=0, Operaciones unchanged. Acepta=1 → Operaciones+1, Listo=1 next cycle.
- Reset mid-operation: Cantidad=7, drop Reinicio_n after 3 shift cycles → immediately Valido=0, Ocupado=0, Listo=1, Salida=0, Operaciones=0. After release, Entrada=8'h81, Cantidad=2, Modo=0 → Salida=8'h60.
- Wrap: 256 back-to-back accepted operations → Operaciones reads 0, with each intermediate value seen exactly once.
